// File: rtl/pipeline_pkg.sv
// Shared constants and encodings for the pipeline sequencing controller:
// next-PC source codes, mul/div tracker states and the register-number width.
package pipeline_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_timer.sv
// Tracks occupancy of the multi-cycle mul/div unit and pulses done in the
// last busy cycle, when the result becomes valid.
module muldiv_timer
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [5:0] LOAD_VALUE = 6'(MULDIV_CYCLES - 1);

  muldiv_state_t state, state_next;
  logic [5:0]    count, count_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // A start seen while BUSY cannot be legal (the issuer is stalled in ID),
  // so it is simply not looked at in that state.
  always_comb begin
    state_next = state;
    count_next = count;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          count_next = LOAD_VALUE;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (count == 6'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count - 6'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO interlocks, branch/jump
// redirection and the saturating stall performance counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_W-1:0]       rs_id,
  input  logic [REG_W-1:0]       rt_id,
  input  logic                   uses_rs_id,
  input  logic                   uses_rt_id,
  input  logic                   hilo_use_id,
  input  logic                   jump_id,
  input  logic                   mem_read_ex,
  input  logic [REG_W-1:0]       wr_reg_ex,
  input  logic                   branch_taken_ex,
  input  logic                   muldiv_start_ex,
  output logic                   keep_pc,
  output logic                   keep_if_id,
  output logic                   reset_if_id,
  output logic                   bubble_id_ex,
  output logic [1:0]             pc_sel,
  output logic                   muldiv_busy,
  output logic                   muldiv_done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic timer_busy;
  logic timer_done;
  logic load_use;
  logic hilo_stall;
  logic stall;
  logic stall_cycle;

  muldiv_timer #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(muldiv_start_ex),
    .busy (timer_busy),
    .done (timer_done)
  );

  assign load_use = mem_read_ex && (wr_reg_ex != '0) &&
                    ((uses_rs_id && (rs_id == wr_reg_ex)) ||
                     (uses_rt_id && (rt_id == wr_reg_ex)));

  // The result is valid in the done cycle, so a waiting mfhi goes through then.
  assign hilo_stall = hilo_use_id && timer_busy && !timer_done;
  assign stall      = load_use || hilo_stall;

  assign muldiv_busy = timer_busy && rst_n;
  assign muldiv_done = timer_done && rst_n;

  // A taken branch wins over everything: the ID instruction is on the wrong path.
  always_comb begin
    keep_pc      = 1'b0;
    keep_if_id   = 1'b0;
    reset_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    stall_cycle  = 1'b0;
    if (rst_n) begin
      if (branch_taken_ex) begin
        pc_sel       = PC_SEL_BR;
        reset_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (stall) begin
        keep_pc      = 1'b1;
        keep_if_id   = 1'b1;
        bubble_id_ex = 1'b1;
        stall_cycle  = 1'b1;
      end else if (jump_id) begin
        pc_sel      = PC_SEL_JMP;
        reset_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_cycle && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Watches the ID and EX stages and drives PC hold, IF/ID hold/flush, ID/EX bubble insertion and next-PC source selection. Covers load-use interlock, taken-branch and jump redirection, and tracking of the multi-cycle multiply/divide unit. Sits beside the Controller and the IF_ID/ID_Ex registers and replaces their ad-hoc keep/reset wiring.

## Interface
- MULDIV_CYCLES, 32: cycles the mul/div unit is busy after issue; legal range 2..63.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous and active-low.
- rs_id, rt_id  in  5 each  source register numbers of the instruction in ID.
- uses_rs_id, uses_rt_id  in  1 each  the ID instruction reads that source.
- hilo_use_id  in  1  the ID instruction reads HI/LO (mfhi/mflo) or is itself a mul/div.
- jump_id  in  1  a jump (j/jal/jr) is decoded in ID.
- mem_read_ex  in  1  the EX instruction is a load.
- wr_reg_ex  in  5  destination register of the EX instruction.
- branch_taken_ex  in  1  the branch in EX resolved taken.
- muldiv_start_ex  in  1  a mul/div is in EX this cycle (issue).
- keep_pc  out  1  hold the PC.
- keep_if_id  out  1  hold the IF/ID register.
- reset_if_id  out  1  flush IF/ID to a nop.
- bubble_id_ex  out  1  load a nop into ID/EX.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- muldiv_busy  out  1  the mul/div unit is occupied.
- muldiv_done  out  1  one-cycle pulse when the mul/div result becomes valid.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

## Operation
- FSM states: IDLE and BUSY. The mul/div down-counter is 6 bits.
- IDLE → BUSY when muldiv_start_ex=1. The counter loads MULDIV_CYCLES-1.
- In BUSY the counter decrements each cycle. At counter=0: muldiv_done=1 that cycle, and the state returns to IDLE.
- muldiv_busy=1 exactly while in BUSY.
- A muldiv_start_ex while in BUSY cannot occur: it is stalled in ID. It is ignored.
- load_use = mem_read_ex and wr_reg_ex≠0 and ((uses_rs_id and rs_id=wr_reg_ex) or (uses_rt_id and rt_id=wr_reg_ex)).
- hilo_stall = hilo_use_id and (state=BUSY and not muldiv_done).
- stall = load_use or hilo_stall.
- Priority order, with all outputs combinational from state plus inputs:
  1. branch_taken_ex: pc_sel=01, reset_if_id=1, bubble_id_ex=1, keep_*=0. Any stall or jump that cycle is on the wrong path and is discarded.
  2. stall: keep_pc=1, keep_if_id=1, bubble_id_ex=1, pc_sel=00. A jump in ID is deferred, not taken.
  3. jump_id: pc_sel=10, reset_if_id=1.
  4. Otherwise: all outputs 0 and pc_sel=00.
- A taken branch never cancels an in-flight mul/div, because the mul/div is older. The counter keeps running.
- stall_count increments on every cycle that case 2 applies, and saturates at all-ones.

## Timing
- Reset (rst_n=0 at a clk edge) forces state IDLE, counter 0 and stall_count 0.
- While reset is asserted, all control outputs are 0 and pc_sel=00, regardless of inputs.
- Reset mid-mul/div aborts it with no done pulse.
- Load-use costs exactly 1 stall cycle: the next cycle the load is in MEM and load_use drops.
- Issue at edge N, entering BUSY: muldiv_done is asserted in cycle N+MULDIV_CYCLES-1, counting the first BUSY cycle as N. A dependent mfhi in ID is released in that same cycle.
- Zero-latency decisions: redirect and flush take effect at the next clk edge.

## Structure
- Shared package pipeline_pkg holds:
  - PC_SEL_SEQ/PC_SEL_BR/PC_SEL_JMP constants;
  - the IDLE/BUSY state encoding;
  - the register-number width (5).
- One sub-module is natural: muldiv_timer, containing the FSM, counter, busy and done. Hazard and priority logic stays in the top.

## Test plan
- Load-use: lw $3 in EX, add using rs=3 in ID → exactly one cycle with keep_pc=keep_if_id=bubble_id_ex=1, stall_count=1. Repeat with wr_reg_ex=0 → no stall.
- Branch plus hazard: branch_taken_ex=1 with a simultaneous load_use and jump_id → pc_sel=01, reset_if_id=1, bubble_id_ex=1, keep_pc=0, stall_count unchanged.
- Mul/div: MULDIV_CYCLES=4, muldiv_start_ex pulse, then mfhi in ID → 3 stall cycles, done pulse in the 4th BUSY cycle with no stall, then IDLE.
- Jump deferral: jr with rs=5 in ID while lw $5 is in EX → stall with pc_sel=00. The next cycle gives pc_sel=10 and reset_if_id=1.
- Reset mid-mul/div: rst_n low in the 2nd BUSY cycle → next cycle IDLE, muldiv_busy=0, no done pulse, stall_count=0.
- Saturation: STALL_CNT_W=4 and 20 consecutive stall cycles → stall_count holds at 15.
